// File: rtl/dct_seq_pkg.sv
// Shared types and defaults for the 8x8 DCT block sequencer.
// Holds the sequencer state encoding and the pipeline geometry constants.
package dct_seq_pkg;

    localparam int ADDR_W_DEF  = 15;
    localparam int LAT_DEF     = 19;
    localparam int TP2_OFS_DEF = 9;
    localparam int BLK_ROWS    = 8;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        RUN,
        DRAIN,
        FIN
    } seq_state_t;

    // Busy-phase state for a cycle, given whether it reads and/or writes.
    function automatic seq_state_t busy_state(input logic reading, input logic writing);
        if (reading && writing) return RUN;
        if (reading)            return FILL;
        return DRAIN;
    endfunction

endpackage

// File: rtl/dct_block_sequencer_pingpong_phase.sv
// Mod-8 phase counter with a start offset; drives one ping-pong select and row phase.
// Stays cleared until OFFSET cycles after load, then toggles sel every BLK_ROWS steps.
module pingpong_phase
    import dct_seq_pkg::*;
#(
    parameter int OFFSET = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       step,
    output logic       sel,
    output logic [2:0] phase
);

    localparam int LW = (OFFSET < 2) ? 1 : $clog2(OFFSET + 1);

    logic [LW-1:0] lead;
    logic          active;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lead   <= '0;
            active <= 1'b0;
            sel    <= 1'b0;
            phase  <= '0;
        end else if (load) begin
            lead   <= LW'(OFFSET);
            active <= (OFFSET == 0);
            sel    <= (OFFSET == 0);
            phase  <= '0;
        end else if (step) begin
            if (active) begin
                phase <= phase + 3'd1;
                if (phase == 3'(BLK_ROWS - 1))
                    sel <= ~sel;
            end else if (lead == LW'(1)) begin
                // Offset elapsed: first half of the ping-pong starts now.
                active <= 1'b1;
                sel    <= 1'b1;
                lead   <= '0;
            end else begin
                lead <= lead - LW'(1);
            end
        end else begin
            lead   <= '0;
            active <= 1'b0;
            sel    <= 1'b0;
            phase  <= '0;
        end
    end

endmodule

// File: rtl/dct_block_sequencer.sv
// Control sequencer for the 2-D 8x8 DCT pipeline: SRAM read/write addressing,
// transpose ping-pong selects and second-stage row index for a block job.
module dct_block_sequencer
    import dct_seq_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int LAT     = LAT_DEF,
    parameter int TP2_OFS = TP2_OFS_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-3:0] cfg_nblk,
    output logic [ADDR_W-1:0] in_addr,
    output logic              in_rd,
    output logic              tp1_sel,
    output logic              tp2_sel,
    output logic [2:0]        row_idx,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_we,
    output logic              busy,
    output logic              done
);

    localparam int TW = ADDR_W + 2;

    seq_state_t  state;
    logic [TW-1:0] t;
    logic [TW-1:0] w;

    logic          accept;
    logic          in_job;
    logic          load;
    logic          step;
    logic [TW-1:0] t_inc;
    logic [TW-1:0] end_t;
    logic          reading;
    logic          writing;
    logic [2:0]    tp1_phase_unused;

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        accept  = 1'b0;
        in_job  = 1'b0;
        t_inc   = t + TW'(1);
        end_t   = w + TW'(LAT);
        reading = (t_inc < w);
        writing = (t_inc >= TW'(LAT));
        if (state == IDLE || state == FIN)
            accept = start;
        if (state == FILL || state == RUN || state == DRAIN)
            in_job = 1'b1;
        load = accept && (cfg_nblk != '0);
        step = in_job && !abort && (t_inc != end_t);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            t        <= '0;
            w        <= '0;
            in_addr  <= '0;
            in_rd    <= 1'b0;
            out_addr <= '0;
            out_we   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            in_addr  <= '0;
            in_rd    <= 1'b0;
            out_addr <= '0;
            out_we   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            case (state)
                IDLE, FIN: begin
                    // A start during the done cycle launches back-to-back.
                    state <= IDLE;
                    if (accept) begin
                        if (cfg_nblk == '0) begin
                            state <= FIN;
                            done  <= 1'b1;
                        end else begin
                            state <= FILL;
                            t     <= '0;
                            w     <= TW'(cfg_nblk) * TW'(BLK_ROWS);
                            busy  <= 1'b1;
                            in_rd <= 1'b1;
                        end
                    end
                end
                FILL, RUN, DRAIN: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (t_inc == end_t) begin
                        state <= FIN;
                        done  <= 1'b1;
                    end else begin
                        state  <= busy_state(reading, writing);
                        t      <= t_inc;
                        busy   <= 1'b1;
                        in_rd  <= reading;
                        out_we <= writing;
                        if (reading)
                            in_addr <= t_inc[ADDR_W-1:0];
                        if (writing)
                            out_addr <= t_inc[ADDR_W-1:0] - ADDR_W'(LAT);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    pingpong_phase #(.OFFSET(0)) u_tp1 (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .step  (step),
        .sel   (tp1_sel),
        .phase (tp1_phase_unused)
    );

    pingpong_phase #(.OFFSET(TP2_OFS)) u_tp2 (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .step  (step),
        .sel   (tp2_sel),
        .phase (row_idx)
    );

endmodule
